// File: rtl/mfm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mfm_pkg
//  Description : Shared constants for the MFM flux-transition generator.
//  Revision    : 1.0  initial release
// ============================================================================
package mfm_pkg;

    localparam int MFM_PULSE_W    = 3;
    localparam int MFM_CELL_CLKS  = 4;
    localparam int MFM_PULSE_CLKS = 1;

    // Nominal interval codes produced by the MFM encoder
    localparam int MFM_2T = 2;
    localparam int MFM_3T = 3;
    localparam int MFM_4T = 4;

endpackage : mfm_pkg
`default_nettype wire

// File: rtl/mfm_shift.sv
`default_nettype none
// ============================================================================
//  Module      : mfm_shift
//  Description : Emits one flux pulse per captured interval of pulses*CELL_CLKS
//                cycles and flags completion on done.
//  Revision    : 1.0  initial release
// ============================================================================
module mfm_shift
    import mfm_pkg::*;
#(
    parameter int PULSE_W    = MFM_PULSE_W,
    parameter int CELL_CLKS  = MFM_CELL_CLKS,
    parameter int PULSE_CLKS = MFM_PULSE_CLKS,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [PULSE_W-1:0] pulses,
    output logic               so,
    output logic               done
);

    localparam logic [CNT_W-1:0] C_PULSE_CLKS = CNT_W'(PULSE_CLKS);
    localparam logic [CNT_W-1:0] C_CELL_CLKS  = CNT_W'(CELL_CLKS);
    localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] len_q,    len_d;
    logic             so_q,     so_d;
    logic             done_q,   done_d;

    logic [CNT_W-1:0] len_new;
    logic [CNT_W-1:0] cnt_inc;
    logic             start;

    assign len_new = CNT_W'(pulses) * C_CELL_CLKS;
    assign cnt_inc = cnt_q + C_ONE;
    // A zero-length request is ignored, so an active interval keeps running.
    assign start   = load && (pulses != '0);

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        so_d     = so_q;
        done_d   = done_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            len_d    = len_new;
            so_d     = 1'b1;
            done_d   = 1'b0;
        end else if (active_q) begin
            if (cnt_q == len_q - C_ONE) begin
                active_d = 1'b0;
                cnt_d    = '0;
                so_d     = 1'b0;
                done_d   = 1'b1;
            end else begin
                cnt_d = cnt_inc;
                so_d  = (cnt_inc < C_PULSE_CLKS);
            end
        end else begin
            so_d   = 1'b0;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            len_q    <= '0;
            so_q     <= 1'b0;
            done_q   <= 1'b1;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            so_q     <= so_d;
            done_q   <= done_d;
        end
    end

    assign so   = so_q;
    assign done = done_q;

endmodule : mfm_shift
`default_nettype wire

// File: tb/tb_mfm_shift.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mfm_shift
//  Description : Directed self-checking bench for mfm_shift (default config).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mfm_shift;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [2:0] pulses;
    logic       so;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    mfm_shift dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .pulses (pulses),
        .so     (so),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // Expected outputs k edges after the load edge, for an interval of L cycles
    task automatic chk_k(input string tag, input int k, input int L);
        chk({tag, "_so"},   so,   (k < 1) && (k < L));
        chk({tag, "_done"}, done, (k >= L));
    endtask

    task automatic do_load(input logic [2:0] p);
        load   = 1'b1;
        pulses = p;
        tick();
        load   = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b1;
        load   = 1'b0;
        pulses = 3'd0;

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk("rst_so",   so,   1'b0);
        chk("rst_done", done, 1'b1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_so",   so,   1'b0);
            chk("idle_done", done, 1'b1);
        end

        // pulses=2: L=8
        do_load(3'd2);
        chk_k("p2", 0, 8);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk_k("p2", k, 8);
        end

        // pulses=3: L=12; pulses changes mid-interval without effect
        do_load(3'd3);
        chk_k("p3", 0, 12);
        for (int k = 1; k <= 13; k++) begin
            if (k == 3) pulses = 3'd4;
            tick();
            chk_k("p3", k, 12);
        end

        // pulses=5 (L=20), reload with pulses=3 on edge 18
        do_load(3'd5);
        chk_k("p5", 0, 20);
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk_k("p5", k, 20);
        end
        do_load(3'd3);
        chk("reload_so",   so,   1'b1);
        chk("reload_done", done, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk_k("reload", k, 12);
        end

        // Reload exactly on the completion edge of an L=8 interval
        do_load(3'd2);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk_k("b2b_a", k, 8);
        end
        do_load(3'd2);
        chk("b2b_so",   so,   1'b1);
        chk("b2b_done", done, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk_k("b2b_b", k, 8);
        end

        // Zero-length load is a no-op
        do_load(3'd0);
        chk("zero_so",   so,   1'b0);
        chk("zero_done", done, 1'b1);
        tick();
        chk("zero_so2",   so,   1'b0);
        chk("zero_done2", done, 1'b1);

        // Load held for three cycles: interval counts from the last one
        load   = 1'b1;
        pulses = 3'd2;
        tick();
        tick();
        do_load(3'd2);
        chk_k("held", 0, 8);
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk_k("held", k, 8);
        end

        // Reset asserted mid-interval of pulses=4
        do_load(3'd4);
        tick();
        tick();
        chk("prerst_done", done, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_so",   so,   1'b0);
        chk("midrst_done", done, 1'b1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("postrst_so",   so,   1'b0);
            chk("postrst_done", done, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mfm_shift
`default_nettype wire
